// File: rtl/fetch_controller.sv
// fetch_controller: program counter and instruction fetch sequencer for the
// picoMIPS core. Drives the combinational program memory address from the PC,
// registers the returned word with a valid flag, and applies halt, stall,
// absolute jump and relative branch requests from the decode stage.
//
// Handshake: instr_valid qualifies instruction/instr_addr for decode. There is
// no ready; the decoder applies back-pressure with stall, which freezes the
// PC and the instruction register (including instr_valid) for that edge.
module fetch_controller #(
    parameter int P_SIZE = 6,
    parameter int I_SIZE = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              stall,
    input  logic              halt,
    input  logic              jump,
    input  logic [P_SIZE-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [P_SIZE-1:0] branch_offset,
    output logic [P_SIZE-1:0] address,
    input  logic [I_SIZE-1:0] mem_instruction,
    output logic [I_SIZE-1:0] instruction,
    output logic [P_SIZE-1:0] instr_addr,
    output logic              instr_valid,
    output logic              halted,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [P_SIZE-1:0] PC_ONE = P_SIZE'(1);

    state_t            state, state_next;
    logic [P_SIZE-1:0] pc, pc_next;
    logic [I_SIZE-1:0] instruction_next;
    logic [P_SIZE-1:0] instr_addr_next;
    logic              instr_valid_next;
    logic              halted_next;

    // Memory address comes straight from the PC; the read is combinational.
    assign address   = pc;
    assign fsm_state = state;

    // State, PC and output registers; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instruction <= '0;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instruction <= instruction_next;
            instr_addr  <= instr_addr_next;
            instr_valid <= instr_valid_next;
            halted      <= halted_next;
        end
    end

    // Next-state and next-register values; everything holds unless changed.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instruction_next = instruction;
        instr_addr_next  = instr_addr;
        instr_valid_next = instr_valid;
        halted_next      = halted;

        unique case (state)
            IDLE: begin
                instr_valid_next = 1'b0;
                if (run) begin
                    state_next = FETCH;
                end
            end

            FETCH: begin
                if (halt) begin
                    // Halt wins even over stall; the PC stays on the next
                    // unfetched address so resume continues from there.
                    state_next       = HALTED;
                    instr_valid_next = 1'b0;
                    halted_next      = 1'b1;
                end else if (stall) begin
                    // Full hold; redirect requesters keep their request up
                    // until stall drops.
                end else if (jump) begin
                    pc_next          = jump_target;
                    instr_valid_next = 1'b0;
                end else if (branch_taken) begin
                    // Offset and sum share the PC width, so the sign
                    // extension is implicit and the result wraps modulo
                    // the memory depth.
                    pc_next          = instr_addr + branch_offset;
                    instr_valid_next = 1'b0;
                end else begin
                    instruction_next = mem_instruction;
                    instr_addr_next  = pc;
                    instr_valid_next = 1'b1;
                    pc_next          = pc + PC_ONE;
                end
            end

            HALTED: begin
                instr_valid_next = 1'b0;
                if (run && !halt) begin
                    state_next  = FETCH;
                    halted_next = 1'b0;
                end
            end

            default: begin
                state_next       = IDLE;
                instr_valid_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios for fetch_controller. Program memory
// is modelled as word k = k. Inputs are driven and outputs sampled 1 time unit
// after each rising edge.
module tb_fetch_controller;

    localparam int P_SIZE = 6;
    localparam int I_SIZE = 24;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic              clk;
    logic              reset;
    logic              run;
    logic              stall;
    logic              halt;
    logic              jump;
    logic [P_SIZE-1:0] jump_target;
    logic              branch_taken;
    logic [P_SIZE-1:0] branch_offset;
    logic [P_SIZE-1:0] address;
    logic [I_SIZE-1:0] mem_instruction;
    logic [I_SIZE-1:0] instruction;
    logic [P_SIZE-1:0] instr_addr;
    logic              instr_valid;
    logic              halted;
    logic [1:0]        fsm_state;

    int checks;
    int failures;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: word k holds value k.
    assign mem_instruction = {{(I_SIZE-P_SIZE){1'b0}}, address};

    fetch_controller #(.P_SIZE(P_SIZE), .I_SIZE(I_SIZE)) dut (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
        .stall           (stall),
        .halt            (halt),
        .jump            (jump),
        .jump_target     (jump_target),
        .branch_taken    (branch_taken),
        .branch_offset   (branch_offset),
        .address         (address),
        .mem_instruction (mem_instruction),
        .instruction     (instruction),
        .instr_addr      (instr_addr),
        .instr_valid     (instr_valid),
        .halted          (halted),
        .fsm_state       (fsm_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        run           = 1'b0;
        stall         = 1'b0;
        halt          = 1'b0;
        jump          = 1'b0;
        jump_target   = '0;
        branch_taken  = 1'b0;
        branch_offset = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reset, then pulse run for one edge: FETCH entered, PC = 0, no valid yet.
    task automatic start_fetch();
        do_reset();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // From start_fetch, advance until instr_addr = n (n+1 fetch edges).
    task automatic run_to(input int n);
        for (int i = 0; i <= n; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (address !== 6'd0) begin $display("FAIL reset_address got=%0d exp=0", address); failures++; end
        checks++; if (instruction !== 24'd0) begin $display("FAIL reset_instruction got=%0d exp=0", instruction); failures++; end
        checks++; if (instr_addr !== 6'd0) begin $display("FAIL reset_instr_addr got=%0d exp=0", instr_addr); failures++; end
        checks++; if (instr_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", instr_valid); failures++; end
        checks++; if (halted !== 1'b0) begin $display("FAIL reset_halted got=%b exp=0", halted); failures++; end
        checks++; if (fsm_state !== S_IDLE) begin $display("FAIL reset_state got=%0d exp=%0d", fsm_state, S_IDLE); failures++; end
        // Without run the controller stays idle and never advances the PC.
        for (int i = 0; i < 3; i++) tick();
        checks++; if (address !== 6'd0 || instr_valid !== 1'b0 || fsm_state !== S_IDLE) begin
            $display("FAIL idle_hold got addr=%0d valid=%b state=%0d exp addr=0 valid=0 state=0", address, instr_valid, fsm_state); failures++;
        end
    endtask

    task automatic test_sequential();
        logic [P_SIZE-1:0] ea;
        start_fetch();
        checks++; if (fsm_state !== S_FETCH || instr_valid !== 1'b0 || address !== 6'd0) begin
            $display("FAIL seq_entry got state=%0d valid=%b addr=%0d exp state=1 valid=0 addr=0", fsm_state, instr_valid, address); failures++;
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_addr !== 6'd0 || instruction !== 24'd0 || address !== 6'd1) begin
            $display("FAIL seq_first got valid=%b ia=%0d ins=%0d addr=%0d exp 1/0/0/1", instr_valid, instr_addr, instruction, address); failures++;
        end
        // Step through the whole memory and past the 63 -> 0 wrap.
        for (int k = 1; k <= 66; k++) begin
            tick();
            ea = k[P_SIZE-1:0];
            checks++; if (instr_valid !== 1'b1 || instr_addr !== ea || instruction !== {18'd0, ea}) begin
                $display("FAIL seq_step k=%0d got valid=%b ia=%0d ins=%0d exp valid=1 ia=%0d ins=%0d", k, instr_valid, instr_addr, instruction, ea, ea); failures++;
            end
        end
    endtask

    task automatic test_stall();
        start_fetch();
        run_to(5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            // Pulse a jump during the middle stall cycle; it must be ignored.
            jump        = (i == 1);
            jump_target = 6'd40;
            tick();
            checks++; if (instruction !== 24'd5 || instr_addr !== 6'd5 || instr_valid !== 1'b1 || address !== 6'd6) begin
                $display("FAIL stall_hold cyc=%0d got ins=%0d ia=%0d valid=%b addr=%0d exp 5/5/1/6", i, instruction, instr_addr, instr_valid, address); failures++;
            end
        end
        jump  = 1'b0;
        stall = 1'b0;
        tick();
        checks++; if (instruction !== 24'd6 || instr_addr !== 6'd6 || instr_valid !== 1'b1 || address !== 6'd7) begin
            $display("FAIL stall_release got ins=%0d ia=%0d valid=%b addr=%0d exp 6/6/1/7", instruction, instr_addr, instr_valid, address); failures++;
        end
    endtask

    task automatic test_branch();
        // Backward branch: 10 + (-4) = 6.
        start_fetch();
        run_to(10);
        branch_taken  = 1'b1;
        branch_offset = 6'h3C;
        tick();
        branch_taken = 1'b0;
        checks++; if (instr_valid !== 1'b0 || address !== 6'd6) begin
            $display("FAIL branch_back_bubble got valid=%b addr=%0d exp valid=0 addr=6", instr_valid, address); failures++;
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_addr !== 6'd6 || instruction !== 24'd6) begin
            $display("FAIL branch_back_target got valid=%b ia=%0d ins=%0d exp 1/6/6", instr_valid, instr_addr, instruction); failures++;
        end
        // Forward branch wrapping: 62 + 5 = 67 mod 64 = 3.
        start_fetch();
        run_to(62);
        branch_taken  = 1'b1;
        branch_offset = 6'd5;
        tick();
        branch_taken = 1'b0;
        checks++; if (instr_valid !== 1'b0 || address !== 6'd3) begin
            $display("FAIL branch_wrap_bubble got valid=%b addr=%0d exp valid=0 addr=3", instr_valid, address); failures++;
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_addr !== 6'd3 || instruction !== 24'd3) begin
            $display("FAIL branch_wrap_target got valid=%b ia=%0d ins=%0d exp 1/3/3", instr_valid, instr_addr, instruction); failures++;
        end
    endtask

    task automatic test_jump_over_branch();
        start_fetch();
        run_to(3);
        jump          = 1'b1;
        jump_target   = 6'd40;
        branch_taken  = 1'b1;
        branch_offset = 6'h3C;
        tick();
        jump         = 1'b0;
        branch_taken = 1'b0;
        checks++; if (instr_valid !== 1'b0 || address !== 6'd40) begin
            $display("FAIL jump_prio_bubble got valid=%b addr=%0d exp valid=0 addr=40", instr_valid, address); failures++;
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_addr !== 6'd40 || instruction !== 24'd40) begin
            $display("FAIL jump_prio_target got valid=%b ia=%0d ins=%0d exp 1/40/40", instr_valid, instr_addr, instruction); failures++;
        end
    endtask

    task automatic test_back_to_back();
        // Jump to 20, then a branch during the bubble (valid = 0) is still
        // applied, relative to the held instr_addr = 3: 3 + 2 = 5.
        start_fetch();
        run_to(3);
        jump        = 1'b1;
        jump_target = 6'd20;
        tick();
        jump          = 1'b0;
        branch_taken  = 1'b1;
        branch_offset = 6'd2;
        tick();
        branch_taken = 1'b0;
        checks++; if (instr_valid !== 1'b0 || address !== 6'd5 || instr_addr !== 6'd3) begin
            $display("FAIL b2b_bubble got valid=%b addr=%0d ia=%0d exp valid=0 addr=5 ia=3", instr_valid, address, instr_addr); failures++;
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_addr !== 6'd5) begin
            $display("FAIL b2b_target got valid=%b ia=%0d exp valid=1 ia=5", instr_valid, instr_addr); failures++;
        end
    endtask

    task automatic test_halt();
        start_fetch();
        run_to(7);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || address !== 6'd8 || fsm_state !== S_HALTED) begin
            $display("FAIL halt_enter got halted=%b valid=%b addr=%0d state=%0d exp 1/0/8/2", halted, instr_valid, address, fsm_state); failures++;
        end
        tick();
        tick();
        checks++; if (halted !== 1'b1 || address !== 6'd8 || instr_valid !== 1'b0) begin
            $display("FAIL halt_hold got halted=%b addr=%0d valid=%b exp 1/8/0", halted, address, instr_valid); failures++;
        end
        // halt and run together: remain halted.
        halt = 1'b1;
        run  = 1'b1;
        tick();
        halt = 1'b0;
        checks++; if (halted !== 1'b1 || fsm_state !== S_HALTED) begin
            $display("FAIL halt_run_both got halted=%b state=%0d exp 1/2", halted, fsm_state); failures++;
        end
        tick();
        run = 1'b0;
        checks++; if (halted !== 1'b0 || instr_valid !== 1'b0 || fsm_state !== S_FETCH) begin
            $display("FAIL resume_entry got halted=%b valid=%b state=%0d exp 0/0/1", halted, instr_valid, fsm_state); failures++;
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_addr !== 6'd8 || instruction !== 24'd8 || address !== 6'd9) begin
            $display("FAIL resume_fetch got valid=%b ia=%0d ins=%0d addr=%0d exp 1/8/8/9", instr_valid, instr_addr, instruction, address); failures++;
        end
        // halt together with stall still halts.
        tick();
        halt  = 1'b1;
        stall = 1'b1;
        tick();
        halt  = 1'b0;
        stall = 1'b0;
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || address !== 6'd10) begin
            $display("FAIL halt_with_stall got halted=%b valid=%b addr=%0d exp 1/0/10", halted, instr_valid, address); failures++;
        end
    endtask

    task automatic test_async_reset();
        start_fetch();
        run_to(4);
        jump        = 1'b1;
        jump_target = 6'd30;
        tick();
        checks++; if (address !== 6'd30 || instr_valid !== 1'b0) begin
            $display("FAIL areset_pre got addr=%0d valid=%b exp 30/0", address, instr_valid); failures++;
        end
        // Mid-cycle, between edges, with the jump still requested.
        #2;
        reset = 1'b1;
        #1;
        checks++; if (address !== 6'd0 || instruction !== 24'd0 || instr_addr !== 6'd0 || instr_valid !== 1'b0 || halted !== 1'b0 || fsm_state !== S_IDLE) begin
            $display("FAIL areset_now got addr=%0d ins=%0d ia=%0d valid=%b halted=%b state=%0d exp all 0", address, instruction, instr_addr, instr_valid, halted, fsm_state); failures++;
        end
        clear_inputs();
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (address !== 6'd0 || instr_valid !== 1'b0 || fsm_state !== S_IDLE) begin
            $display("FAIL areset_idle got addr=%0d valid=%b state=%0d exp 0/0/0", address, instr_valid, fsm_state); failures++;
        end
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_addr !== 6'd0 || address !== 6'd1) begin
            $display("FAIL areset_restart got valid=%b ia=%0d addr=%0d exp 1/0/1", instr_valid, instr_addr, address); failures++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump_over_branch();
        test_back_to_back();
        test_halt();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the combinational program memory for the picoMIPS core. Holds the program counter and drives the memory address. Registers the returned instruction with a valid flag and applies stall, relative branch, absolute jump and halt/run control from the decode stage. Sits between `programMemory` and the decoder/control unit.

## Interface
- `P_SIZE`, 6, program address width; memory depth is 2^P_SIZE words
- `I_SIZE`, 24, instruction width
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `run`  in  1  start from IDLE or resume from HALTED
- `stall`  in  1  hold the fetch stage this cycle
- `halt`  in  1  stop fetching
- `jump`  in  1  absolute redirect request
- `jump_target`  in  P_SIZE  absolute target address
- `branch_taken`  in  1  relative redirect request
- `branch_offset`  in  P_SIZE  two's-complement offset, relative to `instr_addr`
- `address`  out  P_SIZE  program memory address (= PC)
- `mem_instruction`  in  I_SIZE  program memory read data
- `instruction`  out  I_SIZE  registered fetched instruction
- `instr_addr`  out  P_SIZE  address that `instruction` was fetched from
- `instr_valid`  out  1  `instruction` is valid for decode
- `halted`  out  1  controller is in HALTED

## Operation
- States: IDLE, FETCH, HALTED. All outputs and the PC are registered. `address` is driven directly from the PC.
- Reset (asynchronous, any state, including mid-fetch or mid-redirect):
  - state = IDLE
  - PC = 0, `address` = 0
  - `instruction` = 0, `instr_addr` = 0
  - `instr_valid` = 0, `halted` = 0
- IDLE: outputs held and `instr_valid` = 0. When `run` = 1, go to FETCH; the PC is unchanged.
- FETCH: each edge is evaluated in the priority order below. Only the highest active condition applies.
  1. `halt`: go to HALTED. `instr_valid` ← 0, `halted` ← 1. PC held. Applies even if `stall` = 1.
  2. `stall`: PC, `instruction`, `instr_addr` and `instr_valid` are all held. `jump` and `branch_taken` are ignored; requesters hold them until `stall` falls.
  3. `jump`: PC ← `jump_target`. `instr_valid` ← 0, which flushes the sequential fetch made in this cycle.
  4. `branch_taken`: PC ← `instr_addr` + sign-extended `branch_offset`, truncated to P_SIZE bits (wraps modulo 2^P_SIZE). `instr_valid` ← 0.
  5. Otherwise: `instruction` ← `mem_instruction`, `instr_addr` ← PC, `instr_valid` ← 1, PC ← PC + 1. The increment wraps from 2^P_SIZE−1 to 0.
- `jump` has priority over `branch_taken` when both are asserted.
- Redirects assume the redirecting instruction is the one currently in `instruction`. A redirect requested while `instr_valid` = 0 is still applied.
- HALTED: `instr_valid` = 0 and PC held. `run` = 1 → FETCH with `halted` ← 0. If `halt` and `run` are both high, stay HALTED.
- `run` is ignored in FETCH.

## Timing
- Memory read is combinational within the cycle. An instruction is visible on `instruction` one edge after its address is on `address`.
- Throughput is one instruction per cycle with no stall or redirect.
- Redirect penalty is one bubble: the edge that takes the redirect drives `instr_valid` = 0, and the next edge presents the target instruction.
- From IDLE with `run` high at edge N: FETCH from edge N; first valid instruction (address 0) at edge N+1.
- `halt` at edge N: `halted` = 1 and `instr_valid` = 0 after edge N. Resume with `run` at edge M: fetch continues at the held PC, valid after edge M+1.
- `stall` is combinationally sampled at the edge. There is no internal stall latency.

## Test plan
- Reset, then `run` for one cycle; memory holds word k = k: `instr_valid` rises one cycle after FETCH entry; `instruction`/`instr_addr` step 0,1,2,… and wrap 63→0 with P_SIZE = 6.
- `stall` high for 3 cycles while `instruction` = 5: outputs stay at 5/valid for 3 cycles, then 6 follows. A `jump` pulsed during the stall is ignored.
- Branch with `instr_addr` = 10 and `branch_offset` = −4 (6'h3C): one bubble (`instr_valid` = 0), then `instr_addr` = 6. A second case with `instr_addr` = 62 and offset +5 gives `instr_addr` = 3.
- `jump` (target 40) and `branch_taken` asserted together: one bubble, then `instr_addr` = 40.
- `halt` at `instr_addr` = 7: `halted` = 1, `instr_valid` = 0, and `address` is held at 8. Halt asserted together with `stall` also halts. `run` then resumes with `instr_addr` = 8 after one cycle.
- Assert `reset` asynchronously between edges during a redirect: all outputs go to their reset values immediately, and state returns to IDLE; no fetch occurs until `run`.
